axis2native_ppc: RTL and testbench

AXIS2NATIVE_PPC -- requirements
Module: axis2native_ppc

---
 rtl/axis2native_ppc.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axis2native_ppc.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis2native_ppc.sv
// AXI-Stream to native video bridge: FWFT line FIFO, start-of-frame alignment FSM, 1-clk registered timing.
// Optional statistics counters are enabled by defining AXIS2NATIVE_PPC_STATS_EN.
module axis2native_ppc #(
  parameter int DWID       = 24,
  parameter int PPC        = 1,
  parameter int BUF_AWID   = 10,
  parameter int VTG_MASTER = 1,
  parameter int PRIME      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PPC*DWID-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  vtg_hsync,
  input  logic                  vtg_vsync,
  input  logic                  vtg_hblank,
  input  logic                  vtg_vblank,
  input  logic                  vtg_active,
  output logic                  vtg_ce,
  output logic [PPC*DWID-1:0]   natv_data,
  output logic                  natv_hsync,
  output logic                  natv_vsync,
  output logic                  natv_hblank,
  output logic                  natv_vblank,
  output logic                  natv_active,
  input  logic                  clr_status,
  output logic [1:0]            status,
  output logic [BUF_AWID:0]     fifo_level,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           underflow_cnt
);

  localparam int PW    = PPC * DWID;
  localparam int WW    = PW + 2;
  localparam int DEPTH = 1 << BUF_AWID;
  localparam int LW    = BUF_AWID + 1;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [WW-1:0]       mem_r [DEPTH];
  logic [BUF_AWID-1:0] wr_ptr_r;
  logic [BUF_AWID-1:0] rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic [LW-1:0]       level_nxt_s;
  logic [WW-1:0]       head_s;
  logic [PW-1:0]       head_data_s;
  logic                head_last_s;
  logic                head_user_s;
  logic                empty_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                tready_r;
  logic                tready_nxt_s;
  logic                vtg_ce_r;
  logic                sof_flag_r;
  logic                sof_s;
  logic                arm_ok_s;
  logic                run_s;
  logic                uf_s;
  logic                early_s;
  logic                realign_s;
  state_t              state_r;
  state_t              state_nxt_s;
  logic [PW-1:0]       natv_data_r;
  logic                natv_hsync_r;
  logic                natv_vsync_r;
  logic                natv_hblank_r;
  logic                natv_vblank_r;
  logic                natv_active_r;
  logic [1:0]          status_r;

  assign head_s      = mem_r[rd_ptr_r];
  assign head_data_s = head_s[PW-1:0];
  assign head_last_s = head_s[PW];
  assign head_user_s = head_s[PW+1];
  assign empty_s     = (level_r == {LW{1'b0}});
  assign wr_en_s     = s_axis_tvalid && tready_r;
  assign sof_s       = vtg_active && sof_flag_r;

  // FIFO storage; no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  // Next occupancy from the write/read pair
  always_comb begin
    case ({wr_en_s, rd_en_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // tready is registered from the next level so it is exact for the current one
  always_comb begin
    if (VTG_MASTER != 0) begin
      tready_nxt_s = (level_nxt_s < LW'(DEPTH - 4));
    end else begin
      tready_nxt_s = (level_nxt_s < LW'(DEPTH));
    end
  end

  // Master mode must have enough data buffered before committing to a line
  always_comb begin
    if (VTG_MASTER != 0) begin
      arm_ok_s = (level_r >= LW'(PRIME)) || (!empty_s && head_last_s);
    end else begin
      arm_ok_s = 1'b1;
    end
  end

  // FIFO pointers, occupancy and handshake/enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {BUF_AWID{1'b0}};
      rd_ptr_r <= {BUF_AWID{1'b0}};
      level_r  <= {LW{1'b0}};
      tready_r <= 1'b0;
      vtg_ce_r <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + BUF_AWID'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + BUF_AWID'(1);
      level_r  <= level_nxt_s;
      tready_r <= tready_nxt_s;
      vtg_ce_r <= (VTG_MASTER != 0) || (state_nxt_s == ST_ARM) || (state_nxt_s == ST_RUN);
    end
  end

  // Start-of-frame flag: armed by vertical blanking, consumed by the first active pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_flag_r <= 1'b0;
    end else if (vtg_vblank) begin
      sof_flag_r <= 1'b1;
    end else if (vtg_active) begin
      sof_flag_r <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and FIFO read; the ARM->RUN sof cycle is serviced as a RUN cycle
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    run_s       = 1'b0;
    uf_s        = 1'b0;
    early_s     = 1'b0;
    realign_s   = 1'b0;
    case (state_r)
      ST_SYNC: begin
        if (!empty_s && head_user_s) begin
          state_nxt_s = ST_ARM;
        end else begin
          rd_en_s = !empty_s;
        end
      end
      ST_ARM: begin
        if (sof_s && arm_ok_s) begin
          state_nxt_s = ST_RUN;
          run_s       = 1'b1;
          rd_en_s     = !empty_s;
        end else begin
          realign_s = sof_s;
        end
      end
      ST_RUN: begin
        run_s = 1'b1;
        if (vtg_active && empty_s) begin
          uf_s        = 1'b1;
          state_nxt_s = ST_SYNC;
        end else if (vtg_active && head_user_s && !sof_s) begin
          early_s     = 1'b1;
          state_nxt_s = ST_ARM;
        end else begin
          rd_en_s = vtg_active;
        end
      end
      default: begin
        state_nxt_s = ST_SYNC;
      end
    endcase
  end

  // Native outputs: timing delayed one clock, data only for words actually displayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      natv_data_r   <= {PW{1'b0}};
      natv_hsync_r  <= 1'b0;
      natv_vsync_r  <= 1'b0;
      natv_hblank_r <= 1'b0;
      natv_vblank_r <= 1'b0;
      natv_active_r <= 1'b0;
    end else begin
      natv_data_r   <= (rd_en_s && run_s) ? head_data_s : {PW{1'b0}};
      natv_hsync_r  <= vtg_hsync;
      natv_vsync_r  <= vtg_vsync;
      natv_hblank_r <= vtg_hblank;
      natv_vblank_r <= vtg_vblank;
      natv_active_r <= rd_en_s && run_s;
    end
  end

  // Sticky status; clear wins over a simultaneous set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r <= 2'b00;
    end else if (clr_status) begin
      status_r <= 2'b00;
    end else begin
      status_r <= status_r | {(early_s || realign_s), uf_s};
    end
  end

`ifdef AXIS2NATIVE_PPC_STATS_EN
  logic        frame_s;
  logic [15:0] frame_cnt_r;
  logic [15:0] underflow_cnt_r;

  assign frame_s = ((state_r == ST_ARM) && (state_nxt_s == ST_RUN)) || ((state_r == ST_RUN) && sof_s);

  // Frame counter wraps, underflow counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r     <= 16'd0;
      underflow_cnt_r <= 16'd0;
    end else if (clr_status) begin
      frame_cnt_r     <= 16'd0;
      underflow_cnt_r <= 16'd0;
    end else begin
      if (frame_s) frame_cnt_r <= frame_cnt_r + 16'd1;
      if (uf_s && (underflow_cnt_r != 16'hFFFF)) underflow_cnt_r <= underflow_cnt_r + 16'd1;
    end
  end

  assign frame_cnt     = frame_cnt_r;
  assign underflow_cnt = underflow_cnt_r;
`else
  assign frame_cnt     = 16'd0;
  assign underflow_cnt = 16'd0;
`endif

  assign s_axis_tready = tready_r;
  assign vtg_ce        = vtg_ce_r;
  assign natv_data     = natv_data_r;
  assign natv_hsync    = natv_hsync_r;
  assign natv_vsync    = natv_vsync_r;
  assign natv_hblank   = natv_hblank_r;
  assign natv_vblank   = natv_vblank_r;
  assign natv_active   = natv_active_r;
  assign status        = status_r;
  assign fifo_level    = level_r;

endmodule

// File: tb/tb_axis2native_ppc.sv
// Scoreboard bench for axis2native_ppc: a master-mode and a slave-mode instance share VTG and stream stimulus.
module tb_axis2native_ppc;

  localparam int DW = 8;
  localparam int PPC = 2;
  localparam int AW = 6;
  localparam int PW = DW * PPC;

  typedef struct packed { logic act; logic [PW-1:0] data; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr, sel_slv, mon_en;
  logic [PW-1:0] tdata;
  logic tvalid, tlast, tuser, m_tvalid, sl_tvalid;
  logic hs, vs, hb, vb, act;

  logic m_tready, m_ce, m_hs, m_vs, m_hb, m_vb, m_act;
  logic [PW-1:0] m_data;
  logic [1:0] m_status;
  logic [AW:0] m_level;
  logic [15:0] m_fcnt, m_ucnt;

  logic sl_tready, sl_ce, sl_hs, sl_vs, sl_hb, sl_vb, sl_act;
  logic [PW-1:0] sl_data;
  logic [1:0] sl_status;
  logic [AW:0] sl_level;
  logic [15:0] sl_fcnt, sl_ucnt;

  assign m_tvalid  = tvalid & ~sel_slv;
  assign sl_tvalid = tvalid & sel_slv;

  axis2native_ppc #(.DWID(DW), .PPC(PPC), .BUF_AWID(AW), .VTG_MASTER(1), .PRIME(4)) u_mst (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(m_tvalid), .s_axis_tready(m_tready),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .vtg_hsync(hs), .vtg_vsync(vs), .vtg_hblank(hb),
    .vtg_vblank(vb), .vtg_active(act), .vtg_ce(m_ce), .natv_data(m_data), .natv_hsync(m_hs),
    .natv_vsync(m_vs), .natv_hblank(m_hb), .natv_vblank(m_vb), .natv_active(m_act),
    .clr_status(clr), .status(m_status), .fifo_level(m_level), .frame_cnt(m_fcnt), .underflow_cnt(m_ucnt));

  axis2native_ppc #(.DWID(DW), .PPC(PPC), .BUF_AWID(AW), .VTG_MASTER(0), .PRIME(4)) u_slv (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(sl_tvalid), .s_axis_tready(sl_tready),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .vtg_hsync(hs), .vtg_vsync(vs), .vtg_hblank(hb),
    .vtg_vblank(vb), .vtg_active(act), .vtg_ce(sl_ce), .natv_data(sl_data), .natv_hsync(sl_hs),
    .natv_vsync(sl_vs), .natv_hblank(sl_hb), .natv_vblank(sl_vb), .natv_active(sl_act),
    .clr_status(clr), .status(sl_status), .fifo_level(sl_level), .frame_cnt(sl_fcnt), .underflow_cnt(sl_ucnt));

  int n_vec = 0;
  int n_err = 0;
  exp_t m_q[$];
  exp_t sl_q[$];
  exp_t m_e, sl_e;
  exp_t exp_f [8];

`ifdef AXIS2NATIVE_PPC_STATS_EN
  localparam logic [15:0] EXP_FCNT3 = 16'd3;
  localparam logic [15:0] EXP_UCNT1 = 16'd1;
`else
  localparam logic [15:0] EXP_FCNT3 = 16'd0;
  localparam logic [15:0] EXP_UCNT1 = 16'd0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [PW-1:0] gdat(input logic [7:0] base, input int g);
    logic [7:0] lo;
    lo = base + 8'(2 * g);
    return {lo + 8'd1, lo};
  endfunction

  // Master-mode monitor: every active-region output group is checked against the scoreboard
  always @(negedge clk) begin
    if (mon_en && !sel_slv && rst_n && !m_hb && !m_vb) begin
      if (m_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL m_sb_empty: got active-region data %0h, expected no output", m_data);
      end else begin
        m_e = m_q.pop_front();
        chk("m_natv_active", 32'(m_act), 32'(m_e.act));
        chk("m_natv_data", 32'(m_data), 32'(m_e.data));
      end
    end
  end

  // Slave-mode monitor
  always @(negedge clk) begin
    if (mon_en && sel_slv && rst_n && !sl_hb && !sl_vb) begin
      if (sl_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sl_sb_empty: got active-region data %0h, expected no output", sl_data);
      end else begin
        sl_e = sl_q.pop_front();
        chk("sl_natv_active", 32'(sl_act), 32'(sl_e.act));
        chk("sl_natv_data", 32'(sl_data), 32'(sl_e.data));
      end
    end
  end

  task automatic sync_p();
    @(posedge clk); #1;
  endtask

  task automatic vtg_idle();
    hs = 1'b0; vs = 1'b0; hb = 1'b1; vb = 1'b1; act = 1'b0;
  endtask

  // One VTG position; held while the selected DUT gates the VTG off
  task automatic vtg_tick(input logic v_hs, input logic v_vs, input logic v_hb, input logic v_vb,
                          input logic v_act, input exp_t e);
    logic adv;
    hs = v_hs; vs = v_vs; hb = v_hb; vb = v_vb; act = v_act;
    adv = 1'b0;
    for (int n = 0; n < 200 && !adv; n++) begin
      @(negedge clk);
      adv = sel_slv ? sl_ce : m_ce;
      @(posedge clk); #1;
    end
    if (!adv) begin
      n_vec++; n_err++;
      $display("FAIL vtg_ce_timeout: got vtg_ce=0 for 200 cycles, expected 1");
    end else if (v_act) begin
      if (sel_slv) sl_q.push_back(e);
      else m_q.push_back(e);
    end
  endtask

  // Frame: 2 vblank lines, then 4 lines of 2 active groups + 4 blank cycles
  task automatic run_frame();
    exp_t z;
    int idx;
    z.act = 1'b0; z.data = {PW{1'b0}};
    for (int l = 0; l < 2; l++)
      for (int t = 0; t < 6; t++) vtg_tick(t == 3, l == 0, t >= 2, 1'b1, 1'b0, z);
    for (int l = 0; l < 4; l++)
      for (int t = 0; t < 6; t++) begin
        idx = (t < 2) ? l * 2 + t : 0;
        vtg_tick(t == 3, 1'b0, t >= 2, 1'b0, t < 2, (t < 2) ? exp_f[idx] : z);
      end
    vtg_idle();
  endtask

  task automatic set_exp_full(input logic [7:0] base);
    for (int k = 0; k < 8; k++) begin
      exp_f[k].act = 1'b1;
      exp_f[k].data = gdat(base, k);
    end
  endtask

  task automatic push_word(input logic [PW-1:0] d, input logic u, input logic l);
    logic rdy;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    rdy = 1'b0;
    for (int n = 0; n < 200 && !rdy; n++) begin
      @(negedge clk);
      rdy = sel_slv ? sl_tready : m_tready;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    if (!rdy) begin
      n_vec++; n_err++;
      $display("FAIL tready_timeout: got tready=0 for 200 cycles, expected 1");
    end
  endtask

  task automatic push_frame(input logic [7:0] base, input int ngroups);
    for (int g = 0; g < ngroups; g++) push_word(gdat(base, g), g == 0, (g % 2) == 1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0; tvalid = 1'b0; clr = 1'b0;
    vtg_idle();
    sync_p();
    rst_n = 1'b0;
    #2;
    chk("rst_tready", 32'(m_tready), 32'd0);
    chk("rst_vtg_ce", 32'(m_ce), 32'd0);
    chk("rst_sl_vtg_ce", 32'(sl_ce), 32'd0);
    chk("rst_natv", 32'({m_hs, m_vs, m_hb, m_vb, m_act}), 32'd0);
    chk("rst_level", 32'(m_level), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tready_pre_edge", 32'(m_tready), 32'd0);
    @(negedge clk);
    chk("rel_tready", 32'(m_tready), 32'd1);
    chk("rel_vtg_ce", 32'(m_ce), 32'd1);
    chk("rel_sl_vtg_ce", 32'(sl_ce), 32'd0);
    chk("rel_status", 32'(m_status), 32'd0);
    sync_p();
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sel_slv = 1'b0; mon_en = 1'b0; clr = 1'b0;
    tvalid = 1'b0; tdata = {PW{1'b0}}; tuser = 1'b0; tlast = 1'b0;
    vtg_idle();

    // Nominal: three frames pre-filled
    do_reset();
    push_frame(8'h00, 8); push_frame(8'h10, 8); push_frame(8'h20, 8);
    for (int f = 0; f < 3; f++) begin
      set_exp_full(8'(f * 16));
      run_frame();
    end
    @(negedge clk);
    chk("nom_status", 32'(m_status), 32'd0);
    chk("nom_frame_cnt", 32'(m_fcnt), 32'(EXP_FCNT3));
    chk("nom_level", 32'(m_level), 32'd0);
    sync_p();

    // Junk ahead of the tuser word is discarded
    do_reset();
    for (int j = 0; j < 5; j++) push_word(gdat(8'hA0, j), 1'b0, 1'b0);
    push_frame(8'hB0, 8);
    @(negedge clk);
    chk("junk_level", 32'(m_level), 32'd8);
    sync_p();
    set_exp_full(8'hB0);
    run_frame();

    // Underflow after 5 groups, then recovery
    do_reset();
    push_frame(8'h30, 5);
    set_exp_full(8'h30);
    for (int k = 5; k < 8; k++) begin
      exp_f[k].act = 1'b0; exp_f[k].data = {PW{1'b0}};
    end
    run_frame();
    @(negedge clk);
    chk("uf_status", 32'(m_status), 32'd1);
    chk("uf_cnt", 32'(m_ucnt), 32'(EXP_UCNT1));
    sync_p();
    push_frame(8'h70, 8);
    set_exp_full(8'h70);
    run_frame();
    clr = 1'b1;
    sync_p();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_status", 32'(m_status), 32'd0);
    chk("clr_uf_cnt", 32'(m_ucnt), 32'd0);
    sync_p();

    // Short frame: early tuser forces realign, then aligned output
    do_reset();
    push_frame(8'h40, 6); push_frame(8'h60, 8); push_frame(8'h80, 8);
    set_exp_full(8'h40);
    for (int k = 6; k < 8; k++) begin
      exp_f[k].act = 1'b0; exp_f[k].data = {PW{1'b0}};
    end
    run_frame();
    set_exp_full(8'h60);
    run_frame();
    set_exp_full(8'h80);
    run_frame();
    @(negedge clk);
    chk("early_status", 32'(m_status), 32'd2);
    sync_p();

    // Backpressure at 60 words, then asynchronous reset mid-line
    do_reset();
    for (int g = 0; g < 60; g++) push_word(gdat(8'h00, g), g == 0, 1'b0);
    @(negedge clk);
    chk("bp_level", 32'(m_level), 32'd60);
    chk("bp_tready", 32'(m_tready), 32'd0);
    sync_p();
    tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1 tvalid = 1'b0;
    chk("bp_level_hold", 32'(m_level), 32'd60);
    mon_en = 1'b0;
    hb = 1'b0; vb = 1'b0; act = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ml_active", 32'(m_act), 32'd1);
    chk("ml_data", 32'(m_data), 32'h0100);
    #2 rst_n = 1'b0;
    #1;
    chk("ml_rst_active", 32'(m_act), 32'd0);
    chk("ml_rst_data", 32'(m_data), 32'd0);
    chk("ml_rst_tready", 32'(m_tready), 32'd0);
    chk("ml_rst_ce", 32'(m_ce), 32'd0);
    chk("ml_rst_level", 32'(m_level), 32'd0);
    vtg_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ml_rel_level", 32'(m_level), 32'd0);
    chk("ml_rel_tready", 32'(m_tready), 32'd1);
    sync_p();

    // Slave mode: VTG held until the tuser word is at the head
    sel_slv = 1'b1;
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("slv_ce_empty", 32'(sl_ce), 32'd0);
    sync_p();
    push_word(gdat(8'h50, 0), 1'b1, 1'b0);
    @(negedge clk);
    chk("slv_ce_head", 32'(sl_ce), 32'd0);
    @(negedge clk);
    chk("slv_ce_arm", 32'(sl_ce), 32'd1);
    sync_p();
    for (int g = 1; g < 8; g++) push_word(gdat(8'h50, g), 1'b0, (g % 2) == 1);
    set_exp_full(8'h50);
    run_frame();
    @(negedge clk);
    chk("slv_status", 32'(sl_status), 32'd0);
    chk("m_sb_drained", 32'(m_q.size()), 32'd0);
    chk("sl_sb_drained", 32'(sl_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected $finish");
    $fatal(1, "timeout");
  end

endmodule
